// File: rtl/cal_pkg.sv
// Shared types, state encoding and coefficient/saturation defaults for the
// cal_scheduler calibration engine.
package cal_pkg;

   localparam int DATA_W   = 16;
   localparam int COEF_W   = 16;
   localparam int CH_COUNT = 4;
   localparam int CH_W     = 2;
   localparam int DIFF_W   = DATA_W + 1;
   localparam int PROD_W   = 2 * DIFF_W;
   localparam int GAIN_FRAC = 8;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic        [COEF_W-1:0] coef_gain_t;
   typedef logic signed [DIFF_W-1:0] diff_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic        [CH_W-1:0]   ch_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      CLAMP = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam sample_t    DEF_OFFSET = 16'sd4122;
   localparam coef_gain_t DEF_GAIN   = 16'd269;
   localparam sample_t    CLAMP_HI   = 16'sd26000;
   localparam sample_t    CLAMP_LO   = -16'sd26000;

endpackage

// File: rtl/cal_scheduler_if.sv
// Sample, coefficient and result bundle between the deserialiser/host side
// (master) and the cal_scheduler engine (slave).
interface cal_scheduler_if
   import cal_pkg::*;
();

   logic       strobe;
   sample_t    raw_in0;
   sample_t    raw_in1;
   sample_t    raw_in2;
   sample_t    raw_in3;
   logic       cfg_we;
   ch_t        cfg_ch;
   sample_t    cfg_offset;
   coef_gain_t cfg_gain;
   sample_t    cal_out0;
   sample_t    cal_out1;
   sample_t    cal_out2;
   sample_t    cal_out3;
   logic       out_valid;
   logic       busy;
   logic       overrun;

   modport master (
      output strobe, raw_in0, raw_in1, raw_in2, raw_in3,
      output cfg_we, cfg_ch, cfg_offset, cfg_gain,
      input  cal_out0, cal_out1, cal_out2, cal_out3,
      input  out_valid, busy, overrun
   );

   modport slave (
      input  strobe, raw_in0, raw_in1, raw_in2, raw_in3,
      input  cfg_we, cfg_ch, cfg_offset, cfg_gain,
      output cal_out0, cal_out1, cal_out2, cal_out3,
      output out_valid, busy, overrun
   );

endinterface

// File: rtl/cal_datapath.sv
// Shared calibration arithmetic: (raw - offset) * gain, then >>> 8 and either
// saturation (CAL_CLAMP_EN defined) or two's-complement wrap to 16 bits.
module cal_datapath
   import cal_pkg::*;
(
   input  sample_t    i_raw,
   input  sample_t    i_offset,
   input  coef_gain_t i_gain,
   output prod_t      o_prod,
   input  prod_t      i_prod,
   output sample_t    o_result
);

   diff_t w_diff;
   diff_t w_gain_ext;
   prod_t w_shift;

`ifdef CAL_CLAMP_EN
   // Compare at full product width so large overflows cannot alias into range.
   function automatic sample_t sat_s16(input prod_t v);
      if (v > prod_t'(CLAMP_HI))
         return CLAMP_HI;
      else if (v < prod_t'(CLAMP_LO))
         return CLAMP_LO;
      else
         return sample_t'(v);
   endfunction
`else
   function automatic sample_t sat_s16(input prod_t v);
      return sample_t'(v);
   endfunction
`endif

   assign w_diff     = $signed({i_raw[DATA_W-1], i_raw}) - $signed({i_offset[DATA_W-1], i_offset});
   assign w_gain_ext = $signed({1'b0, i_gain});
   assign o_prod     = prod_t'(w_diff) * prod_t'(w_gain_ext);

   assign w_shift  = i_prod >>> GAIN_FRAC;
   assign o_result = sat_s16(w_shift);

endmodule

// File: rtl/cal_scheduler.sv
// Four-channel calibration scheduler: latches a frame on strobe and sequences
// each channel through cal_datapath (MUL then CLAMP), presenting all results in DONE.
module cal_scheduler
   import cal_pkg::*;
(
   input  logic clk_256fs,
   input  logic rst,
   cal_scheduler_if.slave bus
);

   state_t     r_state;
   state_t     w_next_state;
   logic       w_accept;
   ch_t        r_ch;

   sample_t    w_raw_in      [CH_COUNT];
   sample_t    r_raw         [CH_COUNT];
   sample_t    r_off_live    [CH_COUNT];
   sample_t    r_off_shadow  [CH_COUNT];
   coef_gain_t r_gain_live   [CH_COUNT];
   coef_gain_t r_gain_shadow [CH_COUNT];
   sample_t    r_stage       [CH_COUNT];
   sample_t    r_cal_out     [CH_COUNT];

   prod_t      w_prod;
   prod_t      r_prod_p1;
   sample_t    w_result;
   logic       r_out_valid;
   logic       r_busy;
   logic       r_overrun;

   assign w_raw_in[0] = bus.raw_in0;
   assign w_raw_in[1] = bus.raw_in1;
   assign w_raw_in[2] = bus.raw_in2;
   assign w_raw_in[3] = bus.raw_in3;

   cal_datapath u_dp (
      .i_raw    (r_raw[r_ch]),
      .i_offset (r_off_shadow[r_ch]),
      .i_gain   (r_gain_shadow[r_ch]),
      .o_prod   (w_prod),
      .i_prod   (r_prod_p1),
      .o_result (w_result)
   );

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.strobe) begin
               w_accept     = 1'b1;
               w_next_state = MUL;
            end
         end
         MUL:   w_next_state = CLAMP;
         CLAMP: w_next_state = (r_ch == ch_t'(CH_COUNT - 1)) ? DONE : MUL;
         DONE:  w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_256fs or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // Live coefficients follow cfg_we at all times; the shadow copy taken on
   // accept sees the pre-write values, so a same-cycle write lands next frame.
   always_ff @(posedge clk_256fs or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CH_COUNT; i++) begin
            r_off_live[i]    <= DEF_OFFSET;
            r_gain_live[i]   <= DEF_GAIN;
            r_off_shadow[i]  <= DEF_OFFSET;
            r_gain_shadow[i] <= DEF_GAIN;
            r_raw[i]         <= '0;
         end
      end else begin
         if (bus.cfg_we) begin
            r_off_live[bus.cfg_ch]  <= bus.cfg_offset;
            r_gain_live[bus.cfg_ch] <= bus.cfg_gain;
         end
         if (w_accept) begin
            for (int i = 0; i < CH_COUNT; i++) begin
               r_raw[i]         <= w_raw_in[i];
               r_off_shadow[i]  <= r_off_live[i];
               r_gain_shadow[i] <= r_gain_live[i];
            end
         end
      end
   end

   // ---- stage p1: product register (MUL -> CLAMP) ----
   always_ff @(posedge clk_256fs or posedge rst) begin
      if (rst)
         r_prod_p1 <= '0;
      else if (r_state == MUL)
         r_prod_p1 <= w_prod;
   end

   // ---- stage p2: clamp result into staging; last channel also loads outputs ----
   // Outputs load on the edge into DONE so they and out_valid are visible
   // during the DONE cycle itself.
   always_ff @(posedge clk_256fs or posedge rst) begin
      if (rst) begin
         r_ch        <= '0;
         r_out_valid <= 1'b0;
         for (int i = 0; i < CH_COUNT; i++) begin
            r_stage[i]   <= '0;
            r_cal_out[i] <= '0;
         end
      end else begin
         r_out_valid <= 1'b0;
         if (w_accept)
            r_ch <= '0;
         if (r_state == CLAMP) begin
            r_stage[r_ch] <= w_result;
            if (r_ch == ch_t'(CH_COUNT - 1)) begin
               for (int i = 0; i < CH_COUNT - 1; i++)
                  r_cal_out[i] <= r_stage[i];
               r_cal_out[CH_COUNT-1] <= w_result;
               r_out_valid           <= 1'b1;
            end else begin
               r_ch <= r_ch + ch_t'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_256fs or posedge rst) begin
      if (rst) begin
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_busy    <= (w_next_state != IDLE);
         r_overrun <= bus.strobe && (r_state != IDLE);
      end
   end

   assign bus.cal_out0  = r_cal_out[0];
   assign bus.cal_out1  = r_cal_out[1];
   assign bus.cal_out2  = r_cal_out[2];
   assign bus.cal_out3  = r_cal_out[3];
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = r_busy;
   assign bus.overrun   = r_overrun;

endmodule
